// File: rtl/instruction_buffer.sv
// Dual-issue instruction queue: two pushes and two pops per clock, flush on redirect.
// Optional IBUF_ZERO_INVALID_EN forces read ports with no valid entry behind them to zero.
module instruction_buffer #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [31:0]                  instructionA,
  input  logic [31:0]                  addressA,
  input  logic                         instructionA_valid,
  input  logic [31:0]                  instructionB,
  input  logic [31:0]                  addressB,
  input  logic                         instructionB_valid,
  input  logic                         pop0,
  input  logic                         pop1,
  output logic [31:0]                  entry0_instruction,
  output logic [31:0]                  entry0_address,
  output logic [31:0]                  entry1_instruction,
  output logic [31:0]                  entry1_address,
  output logic [$clog2(DEPTH+1)-1:0]   entry_count,
  output logic                         stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = CW + 1;

  logic [PW-1:0] head_reg;
  logic [PW-1:0] tail_reg;
  logic [CW-1:0] count_reg;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] addr_mem  [DEPTH];

  logic          clear;
  logic          pop0_eff;
  logic          pop1_eff;
  logic          push_a;
  logic          push_b;
  logic [SW-1:0] space;
  logic [PW-1:0] slot_b;
  logic [PW-1:0] head_plus1;

  always_comb begin
    clear    = rst | flush;
    pop0_eff = pop0 && (count_reg != '0);
    pop1_eff = pop0_eff && pop1 && (count_reg >= CW'(2));
    // Slots freed by this cycle's pops are usable by this cycle's pushes.
    space    = SW'(DEPTH) - {1'b0, count_reg} + SW'(pop0_eff) + SW'(pop1_eff);
    push_a   = !clear && instructionA_valid && (space != '0);
    push_b   = !clear && instructionB_valid && (space >= (push_a ? SW'(2) : SW'(1)));
    slot_b   = push_a ? tail_reg + PW'(1) : tail_reg;
    head_plus1 = head_reg + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_reg + PW'(pop0_eff) + PW'(pop1_eff);
      tail_reg  <= tail_reg + PW'(push_a) + PW'(push_b);
      count_reg <= count_reg + CW'(push_a) + CW'(push_b) - CW'(pop0_eff) - CW'(pop1_eff);
    end
  end

  // A and B never target the same slot, so each slot sees at most one writer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic wr_a;
      logic wr_b;
      assign wr_a = push_a && (tail_reg == PW'(gi));
      assign wr_b = push_b && (slot_b == PW'(gi));
      always_ff @(posedge clk) begin
        if (wr_a) begin
          instr_mem[gi] <= instructionA;
          addr_mem[gi]  <= addressA;
        end else if (wr_b) begin
          instr_mem[gi] <= instructionB;
          addr_mem[gi]  <= addressB;
        end
      end
    end
  endgenerate

`ifdef IBUF_ZERO_INVALID_EN
  assign entry0_instruction = (count_reg != '0)      ? instr_mem[head_reg]   : '0;
  assign entry0_address     = (count_reg != '0)      ? addr_mem[head_reg]    : '0;
  assign entry1_instruction = (count_reg >= CW'(2))  ? instr_mem[head_plus1] : '0;
  assign entry1_address     = (count_reg >= CW'(2))  ? addr_mem[head_plus1]  : '0;
`else
  assign entry0_instruction = instr_mem[head_reg];
  assign entry0_address     = addr_mem[head_reg];
  assign entry1_instruction = instr_mem[head_plus1];
  assign entry1_address     = addr_mem[head_plus1];
`endif

  assign entry_count = count_reg;
  assign stall       = count_reg > CW'(DEPTH - 2);

endmodule

// File: tb/tb_instruction_buffer.sv
// Self-checking bench for instruction_buffer: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_instruction_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] instructionA = '0;
  logic [31:0] addressA = '0;
  logic        instructionA_valid = 1'b0;
  logic [31:0] instructionB = '0;
  logic [31:0] addressB = '0;
  logic        instructionB_valid = 1'b0;
  logic        pop0 = 1'b0;
  logic        pop1 = 1'b0;
  logic [31:0] entry0_instruction;
  logic [31:0] entry0_address;
  logic [31:0] entry1_instruction;
  logic [31:0] entry1_address;
  logic [3:0]  entry_count;
  logic        stall;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Reference model: oldest entry at index 0, each element is {instruction, address}.
  logic [63:0] q[$];

  instruction_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .instructionA(instructionA), .addressA(addressA), .instructionA_valid(instructionA_valid),
    .instructionB(instructionB), .addressB(addressB), .instructionB_valid(instructionB_valid),
    .pop0(pop0), .pop1(pop1),
    .entry0_instruction(entry0_instruction), .entry0_address(entry0_address),
    .entry1_instruction(entry1_instruction), .entry1_address(entry1_address),
    .entry_count(entry_count), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got t=%0t want finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic cycle(input logic r, f, av, bv, p0, p1,
                       input logic [31:0] ai, aa, bi, ba);
    int n;
    int pops;
    int space;
    rst = r; flush = f;
    instructionA_valid = av; instructionA = ai; addressA = aa;
    instructionB_valid = bv; instructionB = bi; addressB = ba;
    pop0 = p0; pop1 = p1;
    @(posedge clk);
    n = q.size();
    pops = 0;
    if (p0 && n >= 1) pops = 1;
    if (pops == 1 && p1 && n >= 2) pops = 2;
    if (r || f) begin
      q.delete();
    end else begin
      space = DEPTH - n + pops;
      for (int i = 0; i < pops; i++) void'(q.pop_front());
      if (av && space > 0) begin q.push_back({ai, aa}); space--; end
      if (bv && space > 0) begin q.push_back({bi, ba}); space--; end
    end
    #1;
    cyc++;
    $display("[TB] cyc=%0d rst=%b flush=%b a=%b b=%b pop=%b%b count=%0d stall=%b e0=%h@%h",
             cyc, r, f, av, bv, p0, p1, entry_count, stall, entry0_instruction, entry0_address);
    rst = 1'b0; flush = 1'b0;
    instructionA_valid = 1'b0; instructionB_valid = 1'b0;
    pop0 = 1'b0; pop1 = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    cycle(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
    tests_run++; if (entry_count !== 4'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", entry_count); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL reset_stall: got %b want 0", stall); end
`ifdef IBUF_ZERO_INVALID_EN
    tests_run++; if (entry0_instruction !== 32'h0) begin tests_failed++; $display("FAIL reset_e0: got %h want 0", entry0_instruction); end
    tests_run++; if (entry1_instruction !== 32'h0) begin tests_failed++; $display("FAIL reset_e1: got %h want 0", entry1_instruction); end
`endif
  endtask

  task automatic test_dual_push();
    cycle(0, 0, 1, 1, 0, 0, 32'h11111112, 32'h0, 32'h11111113, 32'h4);
    tests_run++; if (entry_count !== 4'd2) begin tests_failed++; $display("FAIL dual_count: got %0d want 2", entry_count); end
    tests_run++; if ({entry0_instruction, entry0_address} !== {32'h11111112, 32'h0})
      begin tests_failed++; $display("FAIL dual_e0: got %h@%h want 11111112@0", entry0_instruction, entry0_address); end
    tests_run++; if ({entry1_instruction, entry1_address} !== {32'h11111113, 32'h4})
      begin tests_failed++; $display("FAIL dual_e1: got %h@%h want 11111113@4", entry1_instruction, entry1_address); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 2; k++)
      cycle(0, 0, 1, 1, 0, 0, 32'hA0000000 + 2*k, 32'h10 + 8*k, 32'hA0000001 + 2*k, 32'h14 + 8*k);
    tests_run++; if (entry_count !== 4'd6) begin tests_failed++; $display("FAIL fill6_count: got %0d want 6", entry_count); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL fill6_stall: got %b want 0", stall); end
    cycle(0, 0, 1, 1, 0, 0, 32'hA0000010, 32'h40, 32'hA0000011, 32'h44);
    tests_run++; if (entry_count !== 4'd8) begin tests_failed++; $display("FAIL fill8_count: got %0d want 8", entry_count); end
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL fill8_stall: got %b want 1", stall); end
    cycle(0, 0, 1, 1, 0, 0, 32'hDEADBEEF, 32'h80, 32'hDEADBEF0, 32'h84);
    tests_run++; if (entry_count !== 4'd8) begin tests_failed++; $display("FAIL full_drop_count: got %0d want 8", entry_count); end
    tests_run++; if (entry0_instruction !== 32'h11111112) begin tests_failed++; $display("FAIL full_drop_e0: got %h want 11111112", entry0_instruction); end
  endtask

  task automatic test_pop_rules();
    logic [63:0] exp2;
    cycle(0, 0, 0, 0, 1, 1, '0, '0, '0, '0);
    cycle(0, 0, 0, 0, 1, 1, '0, '0, '0, '0);
    cycle(0, 0, 0, 0, 1, 0, '0, '0, '0, '0);
    tests_run++; if (entry_count !== 4'd3) begin tests_failed++; $display("FAIL pop_setup_count: got %0d want 3", entry_count); end
    exp2 = q[2];
    cycle(0, 0, 0, 0, 1, 1, '0, '0, '0, '0);
    tests_run++; if (entry_count !== 4'd1) begin tests_failed++; $display("FAIL pop_both_count: got %0d want 1", entry_count); end
    tests_run++; if ({entry0_instruction, entry0_address} !== exp2)
      begin tests_failed++; $display("FAIL pop_both_e0: got %h@%h want %h", entry0_instruction, entry0_address, exp2); end
    cycle(0, 0, 0, 0, 0, 1, '0, '0, '0, '0);
    tests_run++; if (entry_count !== 4'd1) begin tests_failed++; $display("FAIL pop1_only_count: got %0d want 1", entry_count); end
    tests_run++; if ({entry0_instruction, entry0_address} !== exp2)
      begin tests_failed++; $display("FAIL pop1_only_e0: got %h@%h want %h", entry0_instruction, entry0_address, exp2); end
    cycle(0, 0, 0, 0, 1, 0, '0, '0, '0, '0);
    tests_run++; if (entry_count !== 4'd0) begin tests_failed++; $display("FAIL pop0_last_count: got %0d want 0", entry_count); end
`ifdef IBUF_ZERO_INVALID_EN
    tests_run++; if (entry0_instruction !== 32'h0) begin tests_failed++; $display("FAIL pop0_last_e0: got %h want 0", entry0_instruction); end
`endif
    cycle(0, 0, 0, 0, 1, 1, '0, '0, '0, '0);
    tests_run++; if (entry_count !== 4'd0) begin tests_failed++; $display("FAIL pop_empty_count: got %0d want 0", entry_count); end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 4; k++)
      cycle(0, 0, 1, 1, 0, 0, 32'hC0000000 + 2*k, 32'h100 + 8*k, 32'hC0000001 + 2*k, 32'h104 + 8*k);
    tests_run++; if (entry_count !== 4'd8) begin tests_failed++; $display("FAIL simul_full_count: got %0d want 8", entry_count); end
    cycle(0, 0, 1, 1, 1, 1, 32'h11111111, 32'h200, 32'h11111112, 32'h204);
    tests_run++; if (entry_count !== 4'd8) begin tests_failed++; $display("FAIL simul_count: got %0d want 8", entry_count); end
    tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL simul_stall: got %b want 1", stall); end
    for (int k = 0; k < 4; k++) begin
      tests_run++; if ({entry0_instruction, entry0_address} !== q[0])
        begin tests_failed++; $display("FAIL simul_drain_e0[%0d]: got %h@%h want %h", k, entry0_instruction, entry0_address, q[0]); end
      tests_run++; if ({entry1_instruction, entry1_address} !== q[1])
        begin tests_failed++; $display("FAIL simul_drain_e1[%0d]: got %h@%h want %h", k, entry1_instruction, entry1_address, q[1]); end
      if (k == 3) begin
        tests_run++; if ({entry0_instruction, entry1_instruction} !== {32'h11111111, 32'h11111112})
          begin tests_failed++; $display("FAIL simul_tail_pair: got %h/%h want 11111111/11111112", entry0_instruction, entry1_instruction); end
      end
      cycle(0, 0, 0, 0, 1, 1, '0, '0, '0, '0);
    end
    tests_run++; if (entry_count !== 4'd0) begin tests_failed++; $display("FAIL simul_drained: got %0d want 0", entry_count); end
  endtask

  task automatic test_flush();
    cycle(0, 0, 1, 1, 0, 0, 32'h21, 32'h0, 32'h22, 32'h4);
    cycle(0, 0, 1, 1, 0, 0, 32'h23, 32'h8, 32'h24, 32'hC);
    cycle(0, 0, 1, 0, 0, 0, 32'h25, 32'h10, 32'h0, 32'h0);
    tests_run++; if (entry_count !== 4'd5) begin tests_failed++; $display("FAIL flush_setup_count: got %0d want 5", entry_count); end
    cycle(0, 1, 1, 1, 1, 1, 32'h26, 32'h14, 32'h27, 32'h18);
    tests_run++; if (entry_count !== 4'd0) begin tests_failed++; $display("FAIL flush_count: got %0d want 0", entry_count); end
    tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL flush_stall: got %b want 0", stall); end
`ifdef IBUF_ZERO_INVALID_EN
    tests_run++; if ({entry0_instruction, entry1_instruction} !== 64'h0)
      begin tests_failed++; $display("FAIL flush_entries: got %h/%h want 0/0", entry0_instruction, entry1_instruction); end
`endif
    cycle(0, 0, 1, 0, 0, 0, 32'h55, 32'h300, 32'h0, 32'h0);
    tests_run++; if (entry_count !== 4'd1) begin tests_failed++; $display("FAIL post_flush_count: got %0d want 1", entry_count); end
    tests_run++; if ({entry0_instruction, entry0_address} !== {32'h55, 32'h300})
      begin tests_failed++; $display("FAIL post_flush_e0: got %h@%h want 55@300", entry0_instruction, entry0_address); end
  endtask

  task automatic test_random();
    logic r, f;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 63) == 0);
      f = ($urandom_range(0, 31) == 0);
      cycle(r, f, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, $urandom);
      tests_run++; if (entry_count !== 4'(q.size()))
        begin tests_failed++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, entry_count, q.size()); end
      tests_run++; if (stall !== (q.size() > DEPTH - 2))
        begin tests_failed++; $display("FAIL rand_stall[%0d]: got %b want %b", i, stall, q.size() > DEPTH - 2); end
      if (q.size() >= 1) begin
        tests_run++; if ({entry0_instruction, entry0_address} !== q[0])
          begin tests_failed++; $display("FAIL rand_e0[%0d]: got %h@%h want %h", i, entry0_instruction, entry0_address, q[0]); end
      end
`ifdef IBUF_ZERO_INVALID_EN
      else begin
        tests_run++; if ({entry0_instruction, entry0_address} !== 64'h0)
          begin tests_failed++; $display("FAIL rand_e0_zero[%0d]: got %h@%h want 0", i, entry0_instruction, entry0_address); end
      end
`endif
      if (q.size() >= 2) begin
        tests_run++; if ({entry1_instruction, entry1_address} !== q[1])
          begin tests_failed++; $display("FAIL rand_e1[%0d]: got %h@%h want %h", i, entry1_instruction, entry1_address, q[1]); end
      end
`ifdef IBUF_ZERO_INVALID_EN
      else begin
        tests_run++; if ({entry1_instruction, entry1_address} !== 64'h0)
          begin tests_failed++; $display("FAIL rand_e1_zero[%0d]: got %h@%h want 0", i, entry1_instruction, entry1_address); end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_dual_push();
    test_fill();
    test_pop_rules();
    test_simultaneous();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
